// File: rtl/weighted_rr_packet_arbiter.sv
// rtl/weighted_rr_packet_arbiter.sv - weighted round-robin arbiter with packet-locked registered grants
module weighted_rr_packet_arbiter #(
  parameter int REQUESTERS_QUANT = 4,
  parameter int WEIGHT_W         = 4,
  localparam int N   = REQUESTERS_QUANT,
  localparam int IDW = (REQUESTERS_QUANT > 1) ? $clog2(REQUESTERS_QUANT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  ack,
  input  logic                  last,
  output logic [N-1:0]          grants,
  output logic                  grant_valid,
  output logic [IDW-1:0]        grant_id
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        grants_q, grants_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [WEIGHT_W-1:0] weight_arr [N];
  logic [IDW-1:0]      arb_ptr;
  logic [IDW-1:0]      win_idx;
  logic                win_found;
  logic                do_arb;
  logic                pkt_done;
  int unsigned         scan_idx;

  for (genvar g = 0; g < N; g++) begin : g_weight
    assign weight_arr[g] = weight[g*WEIGHT_W +: WEIGHT_W];
  end

  // First set request scanning circularly from arb_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < N; i++) begin
      scan_idx = 32'(arb_ptr) + 32'(i);
      if (scan_idx >= 32'(N)) scan_idx = scan_idx - 32'(N);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grants_d = grants_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    arb_ptr  = ptr_q;
    do_arb   = 1'b0;
    pkt_done = ack && last;

    case (state_q)
      ST_IDLE: do_arb = 1'b1;
      ST_GRANT: begin
        // Release on abandon (holder dropped req) or on the final packet of the turn.
        if (!req[id_q] || (pkt_done && credit_q == WEIGHT_W'(1))) begin
          arb_ptr = (32'(id_q) == N - 1) ? '0 : id_q + 1'b1;
          ptr_d   = arb_ptr;
          do_arb  = 1'b1;
        end else if (pkt_done) begin
          credit_d = credit_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_arb) begin
      if (win_found) begin
        state_d           = ST_GRANT;
        grants_d          = '0;
        grants_d[win_idx] = 1'b1;
        id_d              = win_idx;
        credit_d          = (weight_arr[win_idx] == '0) ? WEIGHT_W'(1) : weight_arr[win_idx];
      end else begin
        state_d  = ST_IDLE;
        grants_d = '0;
        id_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grants_q <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign grants      = grants_q;
  assign grant_valid = |grants_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_weighted_rr_packet_arbiter.sv
// tb/tb_weighted_rr_packet_arbiter.sv - random and directed checks of two arbiter instances (N=4, N=3)
module tb_weighted_rr_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req4, grants4;
  logic [15:0] w4;
  logic        ack4, last4, gv4;
  logic [1:0]  id4;
  logic [2:0]  req3, grants3;
  logic [11:0] w3;
  logic        ack3, last3, gv3;
  logic [1:0]  id3;

  int n_cmp = 0;
  int n_bad = 0;
  int m_hold [2];
  int m_ptr  [2];
  int m_cred [2];

  always #5 clk = ~clk;

  weighted_rr_packet_arbiter #(.REQUESTERS_QUANT(4), .WEIGHT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .weight(w4), .ack(ack4), .last(last4),
    .grants(grants4), .grant_valid(gv4), .grant_id(id4)
  );

  weighted_rr_packet_arbiter #(.REQUESTERS_QUANT(3), .WEIGHT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .weight(w3), .ack(ack3), .last(last3),
    .grants(grants3), .grant_valid(gv3), .grant_id(id3)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: holder index (-1 = idle), packets left in the turn, rotation pointer.
  task automatic model_step(input int u, input int n, input logic [3:0] rq,
                            input logic [15:0] wt, input logic ak, input logic ls);
    bit rearb;
    int j;
    int wv;
    if (rst) begin
      m_hold[u] = -1; m_ptr[u] = 0; m_cred[u] = 0;
      return;
    end
    rearb = 0;
    if (m_hold[u] < 0) begin
      rearb = 1;
    end else if (!rq[m_hold[u]] || (ak && ls && m_cred[u] == 1)) begin
      m_ptr[u] = (m_hold[u] + 1) % n;
      rearb = 1;
    end else if (ak && ls) begin
      m_cred[u] = m_cred[u] - 1;
    end
    if (rearb) begin
      m_hold[u] = -1;
      for (int k = 0; k < n; k++) begin
        j = (m_ptr[u] + k) % n;
        if (m_hold[u] < 0 && rq[j]) begin
          m_hold[u] = j;
          wv = int'((wt >> (4 * j)) & 16'hF);
          m_cred[u] = (wv == 0) ? 1 : wv;
        end
      end
    end
  endtask

  function automatic int unsigned exp_grants(input int u);
    return (m_hold[u] < 0) ? 0 : (1 << m_hold[u]);
  endfunction

  function automatic int unsigned exp_id(input int u);
    return (m_hold[u] < 0) ? 0 : m_hold[u];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, 4, req4, w4, ack4, last4);
    model_step(1, 3, {1'b0, req3}, {4'h0, w3}, ack3, last3);
    @(negedge clk);
    check_eq("n4_grants", grants4, exp_grants(0));
    check_eq("n4_valid",  gv4, (m_hold[0] >= 0) ? 1 : 0);
    check_eq("n4_id",     id4, exp_id(0));
    check_eq("n3_grants", grants3, exp_grants(1));
    check_eq("n3_valid",  gv3, (m_hold[1] >= 0) ? 1 : 0);
    check_eq("n3_id",     id3, exp_id(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int unsigned seq2 [8] = '{1, 1, 1, 2, 1, 1, 1, 2};

  initial begin
    rst = 1'b1;
    req4 = '0; w4 = 16'h1111; ack4 = 1'b0; last4 = 1'b0;
    req3 = '0; w3 = 12'h000;  ack3 = 1'b0; last3 = 1'b0;
    m_hold = '{-1, -1}; m_ptr = '{0, 0}; m_cred = '{0, 0};
    tick();
    check_eq("reset_grants", grants4, 0);
    check_eq("reset_id", id4, 0);
    rst = 1'b0;

    // Plain rotation, weight 1, one packet per cycle.
    req4 = 4'b1111; ack4 = 1'b1; last4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("t1_rotate", grants4, 1 << (k % 4));
    end

    // Weighted turn: requester 0 holds for 3 packets.
    do_reset();
    w4 = 16'h0013; req4 = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("t2_weighted", grants4, seq2[k]);
    end

    // Multi-beat packet is not split; hand-over without bubble.
    do_reset();
    w4 = 16'h1111; req4 = 4'b0011; ack4 = 1'b0; last4 = 1'b0;
    tick();
    check_eq("t3_first", grants4, 4'b0001);
    ack4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t3_hold", grants4, 4'b0001);
    end
    last4 = 1'b1;
    tick();
    check_eq("t3_handover", grants4, 4'b0010);

    // Abort by holder dropping req mid-packet.
    do_reset();
    req4 = 4'b0101; ack4 = 1'b0; last4 = 1'b0;
    tick();
    check_eq("t4_first", grants4, 4'b0001);
    req4 = 4'b0100;
    tick();
    check_eq("t4_abort", grants4, 4'b0100);

    // Reset mid-packet, then pointer restarts at 0.
    rst = 1'b1;
    tick();
    check_eq("t5_rst_grants", grants4, 0);
    check_eq("t5_rst_valid", gv4, 0);
    check_eq("t5_rst_id", id4, 0);
    rst = 1'b0; req4 = 4'b1001;
    tick();
    check_eq("t5_after_rst", grants4, 4'b0001);

    // N=3 wrap with zero weights; ack while idle is harmless.
    req4 = '0; req3 = 3'b000; ack3 = 1'b1; last3 = 1'b1; w3 = 12'h000;
    tick();
    check_eq("t6_idle_ack", grants3, 0);
    req3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t6_wrap", grants3, 1 << (k % 3));
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) req4[b] = ~req4[b];
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) req3[b] = ~req3[b];
      if ($urandom_range(0, 49) == 0) w4 = 16'($urandom);
      if ($urandom_range(0, 49) == 0) w3 = 12'($urandom);
      ack4  = ($urandom_range(0, 3) != 0);
      last4 = $urandom_range(0, 1) == 1;
      ack3  = ($urandom_range(0, 3) != 0);
      last3 = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
